// File: rtl/uart_prog_loader.sv
// Purpose: UART program loader; 8N1 RX/TX, framed per-channel images written to NUM_CH memories.
// Latency: stop-bit sample to write strobe 1 cycle; frame complete to TX start bit <= 2 cycles.
// Backpressure: none on RX (bytes always accepted); replies wait in a one-deep slot until TX is idle.
// Optional payload checksum byte enabled by defining UART_PROG_CHKSUM_EN.
module uart_prog_loader #(
  parameter int CLK_DIV      = 87,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 15,
  parameter int NUM_CH       = 2,
  parameter int DEB_CYC      = 20000,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic              board_clk,
  input  logic              board_rst,
  input  logic              uart_button,
  input  logic              upg_rx_i,
  output logic              upg_tx_o,
  output logic              upg_active_o,
  output logic [NUM_CH-1:0] upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [DATA_W-1:0] upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_err_o
);

  localparam int NB     = DATA_W / 8;
  localparam int BW     = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW     = $clog2(CLK_DIV);
  localparam int DW     = $clog2(DEB_CYC);
  localparam int TO_LIM = TIMEOUT_BITS * CLK_DIV - 1;
  localparam int TW     = $clog2(TO_LIM + 1);
  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_CNT_LO = 3'd2;
  localparam logic [2:0] ST_CNT_HI = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
`ifdef UART_PROG_CHKSUM_EN
  localparam logic [2:0] ST_CSUM   = 3'd5;
`endif
  localparam logic [2:0] ST_ACK    = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  logic [1:0]        btn_s, rx_s;
  logic              btn_sync, rx_sync, btn_deb, press;
  logic [DW-1:0]     deb_cnt;
  logic              rx_busy, rx_prev, rx_stop, rx_vld, rx_ferr;
  logic [CW-1:0]     rx_cnt, tx_cnt;
  logic [3:0]        rx_bit, tx_bit;
  logic [7:0]        rx_sh, resp_byte, cnt_lo;
  logic              tx_busy, tx_line, resp_pend;
  logic [8:0]        tx_sh;
  logic [2:0]        state, ch;
  logic [15:0]       cnt_in, words_left;
  logic [ADDR_W-1:0] adr_cnt;
  logic [BW-1:0]     byte_idx;
  logic [DATA_W-1:0] word_buf, next_word;
  logic [TW-1:0]     to_cnt;
  logic              timed, to_hit;
`ifdef UART_PROG_CHKSUM_EN
  logic [7:0]        csum;
`endif

  assign btn_sync = btn_s[1];
  assign rx_sync  = rx_s[1];
  assign upg_tx_o = tx_line;
  assign cnt_in   = {rx_sh, cnt_lo};
  assign press    = btn_sync && !btn_deb && (deb_cnt == DW'(DEB_CYC - 1));
  assign rx_stop  = rx_busy && (rx_bit == 4'd9) && (rx_cnt == CW'(CLK_DIV - 1));
  assign rx_vld   = rx_stop && rx_sync;
  assign rx_ferr  = rx_stop && !rx_sync;
`ifdef UART_PROG_CHKSUM_EN
  assign timed = (state == ST_CNT_LO) || (state == ST_CNT_HI) || (state == ST_DATA) || (state == ST_CSUM);
`else
  assign timed = (state == ST_CNT_LO) || (state == ST_CNT_HI) || (state == ST_DATA);
`endif
  assign to_hit = timed && !rx_vld && (to_cnt == TW'(TO_LIM));

  // Two-flop synchronisers for the asynchronous button and RX line.
  always_ff @(posedge board_clk or negedge board_rst) begin
    if (!board_rst) begin
      btn_s <= 2'b00;
      rx_s  <= 2'b11;
    end else begin
      btn_s <= {btn_s[0], uart_button};
      rx_s  <= {rx_s[0], upg_rx_i};
    end
  end

  // Debounce: the button level is accepted only after DEB_CYC stable cycles.
  always_ff @(posedge board_clk or negedge board_rst) begin
    if (!board_rst) begin
      btn_deb <= 1'b0;
      deb_cnt <= '0;
    end else if (btn_sync == btn_deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
      btn_deb <= btn_sync;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

  // RX: start-bit recheck at half a bit, then one sample per bit period, LSB first.
  always_ff @(posedge board_clk or negedge board_rst) begin
    if (!board_rst) begin
      rx_busy <= 1'b0;
      rx_prev <= 1'b1;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
    end else begin
      rx_prev <= rx_sync;
      if (!rx_busy) begin
        if (rx_prev && !rx_sync) begin
          rx_busy <= 1'b1;
          rx_cnt  <= '0;
          rx_bit  <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        if (rx_cnt == CW'(CLK_DIV / 2 - 1)) begin
          rx_cnt <= '0;
          if (rx_sync) rx_busy <= 1'b0;   // glitch, not a real start bit
          else         rx_bit  <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
      end else if (rx_cnt == CW'(CLK_DIV - 1)) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
        end else begin
          rx_sh  <= {rx_sync, rx_sh[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
      end
    end
  end

  // TX: picks up the pending reply only when idle, so replies never overlap.
  always_ff @(posedge board_clk or negedge board_rst) begin
    if (!board_rst) begin
      tx_busy <= 1'b0;
      tx_line <= 1'b1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
    end else if (!tx_busy) begin
      tx_line <= 1'b1;
      if (resp_pend) begin
        tx_busy <= 1'b1;
        tx_line <= 1'b0;
        tx_sh   <= {1'b1, resp_byte};
        tx_cnt  <= '0;
        tx_bit  <= '0;
      end
    end else if (tx_cnt == CW'(CLK_DIV - 1)) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
        tx_line <= 1'b1;
      end else begin
        tx_line <= tx_sh[0];
        tx_sh   <= {1'b1, tx_sh[8:1]};
        tx_bit  <= tx_bit + 4'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + CW'(1);
    end
  end

  // Inter-byte idle timer, running only while a frame is open.
  always_ff @(posedge board_clk or negedge board_rst) begin
    if (!board_rst)                 to_cnt <= '0;
    else if (!timed || rx_vld)      to_cnt <= '0;
    else if (to_cnt != TW'(TO_LIM)) to_cnt <= to_cnt + TW'(1);
  end

  // Insert the incoming byte into its little-endian lane of the word being built.
  always_comb begin
    next_word = word_buf;
    next_word[byte_idx*8 +: 8] = rx_sh;
  end

  // Frame FSM: command decode, count, payload assembly, memory writes and replies.
  always_ff @(posedge board_clk or negedge board_rst) begin
    if (!board_rst) begin
      state        <= ST_IDLE;
      upg_active_o <= 1'b0;
      upg_wen_o    <= '0;
      upg_adr_o    <= '0;
      upg_dat_o    <= '0;
      upg_done_o   <= 1'b0;
      upg_err_o    <= 1'b0;
      resp_pend    <= 1'b0;
      resp_byte    <= '0;
      ch           <= '0;
      cnt_lo       <= '0;
      words_left   <= '0;
      adr_cnt      <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
`ifdef UART_PROG_CHKSUM_EN
      csum         <= '0;
`endif
    end else begin
      upg_wen_o <= '0;
      if (resp_pend && !tx_busy) resp_pend <= 1'b0;
      if (rx_ferr) upg_err_o <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (press) begin
            upg_active_o <= 1'b1;
            upg_done_o   <= 1'b0;
            upg_err_o    <= 1'b0;
            state        <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (rx_vld) begin
            if (rx_sh[7:3] == 5'b10100 && {29'd0, rx_sh[2:0]} < 32'(NUM_CH)) begin
              ch    <= rx_sh[2:0];
              state <= ST_CNT_LO;
            end else if (rx_sh == 8'hFF) begin
              resp_pend    <= 1'b1;
              resp_byte    <= 8'hAA;
              upg_done_o   <= 1'b1;
              upg_active_o <= 1'b0;
              state        <= ST_DONE;
            end else begin
              resp_pend <= 1'b1;
              resp_byte <= 8'hEE;
              upg_err_o <= 1'b1;
            end
          end
        end
        ST_CNT_LO: begin
          if (rx_vld) begin
            cnt_lo <= rx_sh;
            state  <= ST_CNT_HI;
          end
        end
        ST_CNT_HI: begin
          if (rx_vld) begin
            if ({17'd0, cnt_in} > MAX_WORDS) begin
              resp_pend <= 1'b1;
              resp_byte <= 8'hEE;
              upg_err_o <= 1'b1;
              state     <= ST_CMD;
            end else if (cnt_in == 16'd0) begin
              state <= ST_ACK;
            end else begin
              words_left <= cnt_in;
              adr_cnt    <= '0;
              byte_idx   <= '0;
`ifdef UART_PROG_CHKSUM_EN
              csum       <= '0;
`endif
              state      <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (rx_vld) begin
            word_buf <= next_word;
`ifdef UART_PROG_CHKSUM_EN
            csum     <= csum + rx_sh;
`endif
            if (byte_idx == BW'(NB - 1)) begin
              byte_idx   <= '0;
              upg_wen_o  <= NUM_CH'(1) << ch;
              upg_adr_o  <= adr_cnt;
              upg_dat_o  <= next_word;
              adr_cnt    <= adr_cnt + ADDR_W'(1);
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) begin
`ifdef UART_PROG_CHKSUM_EN
                state <= ST_CSUM;
`else
                state <= ST_ACK;
`endif
              end
            end else begin
              byte_idx <= byte_idx + BW'(1);
            end
          end
        end
`ifdef UART_PROG_CHKSUM_EN
        ST_CSUM: begin
          if (rx_vld) begin
            if (rx_sh == csum) begin
              state <= ST_ACK;
            end else begin
              resp_pend <= 1'b1;
              resp_byte <= 8'hEE;
              upg_err_o <= 1'b1;
              state     <= ST_CMD;
            end
          end
        end
`endif
        ST_ACK: begin
          if (!resp_pend) begin
            resp_pend <= 1'b1;
            resp_byte <= 8'h55;
            state     <= ST_CMD;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A stalled frame is abandoned; words already written are left in memory.
      if (to_hit) begin
        resp_pend <= 1'b1;
        resp_byte <= 8'hEE;
        upg_err_o <= 1'b1;
        state     <= ST_CMD;
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed frames, write and TX reply scoreboards.
// Small CLK_DIV / DEB_CYC keep runtime short; TIMEOUT_BITS kept at the default.
// Checksum steps only run when UART_PROG_CHKSUM_EN is defined.
module tb_uart_prog_loader;
  localparam int CLK_DIV      = 8;
  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 15;
  localparam int NUM_CH       = 2;
  localparam int DEB_CYC      = 16;
  localparam int TIMEOUT_BITS = 64;

  logic              board_clk = 1'b0;
  logic              board_rst = 1'b0;
  logic              uart_button = 1'b0;
  logic              upg_rx_i = 1'b1;
  logic              upg_tx_o;
  logic              upg_active_o;
  logic [NUM_CH-1:0] upg_wen_o;
  logic [ADDR_W-1:0] upg_adr_o;
  logic [DATA_W-1:0] upg_dat_o;
  logic              upg_done_o;
  logic              upg_err_o;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [63:0] wr_exp;

  uart_prog_loader #(
    .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .NUM_CH(NUM_CH), .DEB_CYC(DEB_CYC), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .board_clk(board_clk), .board_rst(board_rst), .uart_button(uart_button),
    .upg_rx_i(upg_rx_i), .upg_tx_o(upg_tx_o), .upg_active_o(upg_active_o),
    .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o), .upg_dat_o(upg_dat_o),
    .upg_done_o(upg_done_o), .upg_err_o(upg_err_o)
  );

  always #5 board_clk = ~board_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_wr(input int c, input int adr, input logic [31:0] dat);
    logic [1:0] oh;
    oh = 2'(1 << c);
    return {15'd0, oh, 15'(adr), dat};
  endfunction

  // Write-port monitor: every strobe cycle must match the next expected write.
  always @(negedge board_clk) begin
    if (board_rst && upg_wen_o != '0) begin
      check("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
      if (exp_wr.size() != 0) begin
        wr_exp = exp_wr.pop_front();
        check("wr", {15'd0, upg_wen_o, upg_adr_o, upg_dat_o}, wr_exp);
      end
    end
  end

  // TX monitor: decode 8N1 from the line and compare against expected replies.
  always begin : tx_mon
    logic [7:0] b;
    logic [7:0] e;
    @(negedge upg_tx_o);
    repeat (CLK_DIV / 2) @(negedge board_clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CLK_DIV) @(negedge board_clk);
      b[i] = upg_tx_o;
    end
    repeat (CLK_DIV) @(negedge board_clk);
    check("tx_stop", 64'(upg_tx_o), 64'd1);
    check("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
    if (exp_tx.size() != 0) begin
      e = exp_tx.pop_front();
      check("tx_byte", 64'(b), 64'(e));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    upg_rx_i = 1'b0;
    repeat (CLK_DIV) @(negedge board_clk);
    for (int i = 0; i < 8; i++) begin
      upg_rx_i = b[i];
      repeat (CLK_DIV) @(negedge board_clk);
    end
    upg_rx_i = 1'b1;
    repeat (CLK_DIV) @(negedge board_clk);
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic press();
    uart_button = 1'b1;
    repeat (DEB_CYC + 8) @(negedge board_clk);
    uart_button = 1'b0;
    repeat (DEB_CYC + 8) @(negedge board_clk);
  endtask

  // Bounded wait for both scoreboards to empty, then a quiet window to catch extras.
  task automatic drain(input int budget);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_tx.size() != 0) && n < budget) begin
      @(negedge board_clk);
      n++;
    end
    check("drain_wr", 64'(exp_wr.size()), 64'd0);
    check("drain_tx", 64'(exp_tx.size()), 64'd0);
    exp_wr.delete();
    exp_tx.delete();
    repeat (12 * CLK_DIV) @(negedge board_clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge board_clk);
    check("rst_tx", 64'(upg_tx_o), 64'd1);
    check("rst_active", 64'(upg_active_o), 64'd0);
    check("rst_wen", 64'(upg_wen_o), 64'd0);
    check("rst_adr", 64'(upg_adr_o), 64'd0);
    check("rst_dat", 64'(upg_dat_o), 64'd0);
    check("rst_done", 64'(upg_done_o), 64'd0);
    check("rst_err", 64'(upg_err_o), 64'd0);
    board_rst = 1'b1;
    repeat (5) @(negedge board_clk);

    // Bounce shorter than the debounce window is ignored
    uart_button = 1'b1;
    repeat (DEB_CYC / 2) @(negedge board_clk);
    uart_button = 1'b0;
    repeat (DEB_CYC * 2) @(negedge board_clk);
    check("bounce_active", 64'(upg_active_o), 64'd0);
    press();
    check("press_active", 64'(upg_active_o), 64'd1);
    check("press_done", 64'(upg_done_o), 64'd0);

    // Two-word frame to channel 0
    exp_wr.push_back(mk_wr(0, 0, 32'h12345678));
    exp_wr.push_back(mk_wr(0, 1, 32'hDEADBEEF));
    exp_tx.push_back(8'h55);
    send_seq('{8'hA0, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    drain(3000);
    check("frame1_err", 64'(upg_err_o), 64'd0);

    // Empty frame to channel 1, then end command
    exp_tx.push_back(8'h55);
    send_seq('{8'hA1, 8'h00, 8'h00});
    drain(3000);
    exp_tx.push_back(8'hAA);
    send_byte(8'hFF);
    drain(3000);
    check("end_done", 64'(upg_done_o), 64'd1);
    check("end_active", 64'(upg_active_o), 64'd0);

    // Re-enter program mode; bad channel then a valid frame on channel 1
    press();
    check("repress_active", 64'(upg_active_o), 64'd1);
    check("repress_done", 64'(upg_done_o), 64'd0);
    exp_tx.push_back(8'hEE);
    send_byte(8'hA7);
    drain(3000);
    check("badcmd_err", 64'(upg_err_o), 64'd1);
    exp_wr.push_back(mk_wr(1, 0, 32'h44332211));
    exp_tx.push_back(8'h55);
    send_seq('{8'hA1, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
    drain(3000);
    check("err_sticky", 64'(upg_err_o), 64'd1);

    // Leave and re-enter to clear err
    exp_tx.push_back(8'hAA);
    send_byte(8'hFF);
    drain(3000);
    press();
    check("clear_err", 64'(upg_err_o), 64'd0);

    // Stall after 5 payload bytes: one word written, then timeout reply
    exp_wr.push_back(mk_wr(0, 0, 32'h04030201));
    exp_tx.push_back(8'hEE);
    send_seq('{8'hA0, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
    drain(TIMEOUT_BITS * CLK_DIV * 3);
    check("timeout_err", 64'(upg_err_o), 64'd1);
    check("timeout_active", 64'(upg_active_o), 64'd1);

    // Async reset in the middle of a DATA byte
    send_seq('{8'hA0, 8'h01, 8'h00, 8'h99});
    upg_rx_i = 1'b0;
    repeat (3) @(negedge board_clk);
    board_rst = 1'b0;
    #1;
    check("arst_tx", 64'(upg_tx_o), 64'd1);
    check("arst_active", 64'(upg_active_o), 64'd0);
    check("arst_err", 64'(upg_err_o), 64'd0);
    check("arst_dat", 64'(upg_dat_o), 64'd0);
    check("arst_wen", 64'(upg_wen_o), 64'd0);
    upg_rx_i = 1'b1;
    repeat (5) @(negedge board_clk);
    board_rst = 1'b1;
    repeat (5) @(negedge board_clk);
    check("arst_idle_active", 64'(upg_active_o), 64'd0);

`ifdef UART_PROG_CHKSUM_EN
    press();
    exp_wr.push_back(mk_wr(0, 0, 32'h04030201));
    exp_tx.push_back(8'h55);
    send_seq('{8'hA0, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A});
    drain(3000);
    check("csum_ok_err", 64'(upg_err_o), 64'd0);
    exp_wr.push_back(mk_wr(0, 0, 32'h04030201));
    exp_tx.push_back(8'hEE);
    send_seq('{8'hA0, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B});
    drain(3000);
    check("csum_bad_err", 64'(upg_err_o), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
